// File: rtl/arb_req_client.sv
// arb_req_client: requester-side agent for a req/grant arbiter.
// Keeps a saturating pending count per channel, requests the arbiter for every
// channel with pending work, and on a legal grant runs a BURST-beat transfer for
// the granted channel followed by IDLE_GAP dead cycles.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push[N]           add one pending transaction per set bit
//   pend_full[N]      channel counter is at its maximum
//   req[N]            request vector to the arbiter (registered)
//   grant[N]          grant vector from the arbiter, expected one-hot
//   busy              transfer or gap in progress
//   xfer_valid/id/beat/last, done   beat stream of the current burst
//   err_grant         pulse after an illegal grant was sampled while idle
module arb_req_client #(
    parameter int unsigned N        = 3,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned BURST    = 4,
    parameter int unsigned IDLE_GAP = 1,
    localparam int unsigned ID_W    = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned BEAT_W  = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      push,
    output logic [N-1:0]      pend_full,
    output logic [N-1:0]      req,
    input  logic [N-1:0]      grant,
    output logic              busy,
    output logic              xfer_valid,
    output logic [ID_W-1:0]   xfer_id,
    output logic [BEAT_W-1:0] xfer_beat,
    output logic              xfer_last,
    output logic              done,
    output logic              err_grant
);

    localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt     [N];
    logic [CNT_W-1:0]   cnt_nxt [N];
    logic [N-1:0]       req_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [BEAT_W-1:0]  beat_inc;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_ok;

    // Next pending counts; a push coinciding with the owning channel's last beat
    // is absorbed by that beat's decrement, even when the counter is full.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = cnt[i];
            if (push[i] && done && (xfer_id == ID_W'(i))) begin
                cnt_nxt[i] = cnt[i];
            end else if (push[i] && !pend_full[i]) begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end else if (done && (xfer_id == ID_W'(i)) && (cnt[i] != '0)) begin
                cnt_nxt[i] = cnt[i] - 1'b1;
            end
            req_nxt[i] = (cnt_nxt[i] != '0);
        end
    end

    // Grant decode: legal only if one-hot and covered by the current request.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
            end
        end
        grant_ok = $onehot(grant) && ((grant & req) == grant);
    end

    assign beat_inc = BEAT_W'(xfer_beat + 1'b1);

    // Control FSM with counters and all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            pend_full  <= '0;
            req        <= '0;
            busy       <= 1'b0;
            xfer_valid <= 1'b0;
            xfer_id    <= '0;
            xfer_beat  <= '0;
            xfer_last  <= 1'b0;
            done       <= 1'b0;
            err_grant  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt[i]       <= cnt_nxt[i];
                pend_full[i] <= (cnt_nxt[i] == CNT_MAX);
            end
            err_grant <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        state      <= S_BURST;
                        busy       <= 1'b1;
                        req        <= '0;
                        xfer_valid <= 1'b1;
                        xfer_id    <= grant_idx;
                        xfer_beat  <= '0;
                        xfer_last  <= (BURST == 1);
                        done       <= (BURST == 1);
                    end else begin
                        req       <= req_nxt;
                        err_grant <= (grant != '0);
                    end
                end
                S_BURST: begin
                    if (xfer_last) begin
                        xfer_valid <= 1'b0;
                        xfer_id    <= '0;
                        xfer_beat  <= '0;
                        xfer_last  <= 1'b0;
                        done       <= 1'b0;
                        if (IDLE_GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            req   <= req_nxt;
                        end
                    end else begin
                        xfer_beat <= beat_inc;
                        xfer_last <= (beat_inc == LAST_BEAT);
                        done      <= (beat_inc == LAST_BEAT);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        req   <= req_nxt;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_req_client.sv
// tb_arb_req_client: directed scenarios plus randomized push/grant traffic,
// checked every cycle against a window-based model of the requester agent.
module tb_arb_req_client;

    localparam int N        = 3;
    localparam int CNT_W    = 4;
    localparam int BURST    = 4;
    localparam int IDLE_GAP = 1;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] push;
    logic [N-1:0] grant;
    logic [N-1:0] pend_full;
    logic [N-1:0] req;
    logic         busy;
    logic         xfer_valid;
    logic [1:0]   xfer_id;
    logic [1:0]   xfer_beat;
    logic         xfer_last;
    logic         done;
    logic         err_grant;

    arb_req_client #(
        .N(N), .CNT_W(CNT_W), .BURST(BURST), .IDLE_GAP(IDLE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .pend_full(pend_full), .req(req),
        .grant(grant), .busy(busy), .xfer_valid(xfer_valid), .xfer_id(xfer_id),
        .xfer_beat(xfer_beat), .xfer_last(xfer_last), .done(done),
        .err_grant(err_grant)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: pending counts plus position inside the burst+gap window.
    // m_pos = -1 when idle, else the index of the current cycle in the window.
    int m_cnt [N] = '{default: 0};
    int m_pos     = -1;
    int m_own     = 0;
    bit m_err     = 1'b0;

    function automatic int exp_req();
        int r = 0;
        if (m_pos >= 0) return 0;
        for (int i = 0; i < N; i++) if (m_cnt[i] > 0) r |= (1 << i);
        return r;
    endfunction

    function automatic int lowest(input int r);
        return r & (-r);
    endfunction

    int  mr_rq;
    bit  mr_dn;
    bit  mr_p;
    bit  mr_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_pos = -1;
            m_own = 0;
            m_err = 1'b0;
        end else begin
            mr_rq = exp_req();
            mr_dn = (m_pos == BURST - 1);
            for (int i = 0; i < N; i++) begin
                mr_p = push[i];
                mr_d = mr_dn && (m_own == i);
                if (mr_p && mr_d) ;
                else if (mr_p && m_cnt[i] < MAXC) m_cnt[i]++;
                else if (mr_d && m_cnt[i] > 0) m_cnt[i]--;
            end
            m_err = 1'b0;
            if (m_pos < 0) begin
                if (grant != 0) begin
                    if ($onehot(grant) && ((int'(grant) & mr_rq) == int'(grant))) begin
                        m_own = $clog2(int'(grant));
                        m_pos = 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else begin
                m_pos++;
                if (m_pos >= BURST + IDLE_GAP) m_pos = -1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    bit cv;
    int cf;
    always @(negedge clk) begin
        cv = (m_pos >= 0) && (m_pos < BURST);
        cf = 0;
        for (int i = 0; i < N; i++) if (m_cnt[i] == MAXC) cf |= (1 << i);
        check("req",        int'(req),        exp_req());
        check("pend_full",  int'(pend_full),  cf);
        check("busy",       int'(busy),       int'(m_pos >= 0));
        check("xfer_valid", int'(xfer_valid), int'(cv));
        check("xfer_id",    int'(xfer_id),    cv ? m_own : 0);
        check("xfer_beat",  int'(xfer_beat),  cv ? m_pos : 0);
        check("xfer_last",  int'(xfer_last),  int'(cv && m_pos == BURST - 1));
        check("done",       int'(done),       int'(cv && m_pos == BURST - 1));
        check("err_grant",  int'(err_grant),  int'(m_err));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int n_done;
    int order [$];
    int seg_density;

    initial begin
        rst   = 1'b1;
        push  = '0;
        grant = '0;
        repeat (3) @(negedge clk);
        check("rst_req", int'(req), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Single push on ch0, granted: 4 beats then one gap cycle.
        @(negedge clk); push = 3'b001;
        @(negedge clk); push = 3'b000;
        check("t1_req", int'(req), 1);
        grant = 3'b001;
        @(negedge clk); grant = 3'b000;
        check("t1_valid0", int'(xfer_valid), 1);
        check("t1_id0", int'(xfer_id), 0);
        check("t1_beat0", int'(xfer_beat), 0);
        for (int b = 1; b < BURST; b++) begin
            @(negedge clk);
            check("t1_beat", int'(xfer_beat), b);
            check("t1_done", int'(done), (b == BURST - 1) ? 1 : 0);
        end
        @(negedge clk);
        check("t1_gap_busy", int'(busy), 1);
        check("t1_gap_valid", int'(xfer_valid), 0);
        check("t1_gap_req", int'(req), 0);
        @(negedge clk);
        check("t1_idle_busy", int'(busy), 0);
        check("t1_idle_req", int'(req), 0);

        // Illegal grants: multi-hot, then a bit without request.
        push = 3'b011;
        @(negedge clk); push = 3'b000;
        check("t5_req", int'(req), 3);
        grant = 3'b011;
        @(negedge clk);
        check("t5_err_multi", int'(err_grant), 1);
        check("t5_busy_multi", int'(busy), 0);
        grant = 3'b100;
        @(negedge clk);
        check("t5_err_noreq", int'(err_grant), 1);
        check("t5_busy_noreq", int'(busy), 0);
        grant = 3'b000;
        @(negedge clk);
        check("t5_err_clear", int'(err_grant), 0);

        // Three channels pending, fixed-priority arbiter serves them in index order.
        push = 3'b100;
        order.delete();
        repeat (30) begin
            @(negedge clk);
            push = 3'b000;
            if (done) order.push_back(int'(xfer_id));
            grant = N'(lowest(exp_req()));
        end
        grant = 3'b000;
        check("t2_bursts", order.size(), 3);
        if (order.size() == 3) begin
            check("t2_first", order[0], 0);
            check("t2_second", order[1], 1);
            check("t2_third", order[2], 2);
        end

        // Saturate ch1, then hold its grant: exactly 15 bursts.
        repeat (20) begin @(negedge clk); push = 3'b010; end
        @(negedge clk); push = 3'b000;
        check("t3_full", int'(pend_full), 2);
        grant = 3'b010;
        n_done = 0;
        repeat (100) begin @(negedge clk); if (done) n_done++; end
        grant = 3'b000;
        check("t3_bursts", n_done, 15);
        check("t3_empty_req", int'(req), 0);

        // ch0 full; push held across a burst keeps it at 15.
        repeat (20) begin @(negedge clk); push = 3'b001; end
        @(negedge clk);
        check("t4_full", int'(pend_full), 1);
        grant = 3'b001;
        @(negedge clk); grant = 3'b000;
        repeat (BURST) @(negedge clk);
        push = 3'b000;
        check("t4_still_full", int'(pend_full), 1);
        grant = 3'b001;
        n_done = 0;
        repeat (100) begin @(negedge clk); if (done) n_done++; end
        grant = 3'b000;
        check("t4_bursts", n_done, 15);

        // Reset in the middle of beat 2.
        @(negedge clk); push = 3'b001;
        @(negedge clk); push = 3'b000; grant = 3'b001;
        @(negedge clk); grant = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("t6_beat2", int'(xfer_beat), 2);
        #1 rst = 1'b1;
        #1;
        check("t6_valid", int'(xfer_valid), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_beat", int'(xfer_beat), 0);
        check("t6_req", int'(req), 0);
        check("t6_full", int'(pend_full), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("t6_req_after", int'(req), 0);
        @(negedge clk);
        check("t6_req_after2", int'(req), 0);

        // Random traffic with varying push density and a mostly well-behaved arbiter.
        for (int seg = 0; seg < 12; seg++) begin
            seg_density = $urandom_range(2, 60);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++)
                    push[i] = ($urandom_range(0, 99) < seg_density);
                case ($urandom_range(0, 99)) inside
                    [0:69]:  grant = N'(lowest(exp_req()));
                    [70:84]: grant = N'($urandom_range(0, 7));
                    default: grant = '0;
                endcase
                if ($urandom_range(0, 499) == 0) begin
                    #2 rst = 1'b1;
                    #1 rst = 1'b0;
                end
            end
        end
        push  = '0;
        grant = '0;
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
